// File: rtl/aim_bot_pkg.sv
// Shared types and default widths for the line-transmit scheduler.
package aim_bot_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_RD, STREAM, GAP} sched_state_t;
  localparam int ID_W  = 5;
  localparam int ROW_W = 11;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set req after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          vld
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/udp_line_scheduler.sv
// Grants one line per packet round-robin, triggers udp_packet, counts payload
// bytes, enforces the inter-packet gap and records protocol errors.
module udp_line_scheduler #(
  parameter int N_REQ      = 2,
  parameter int H_ACT      = 1280,
  parameter int ROW_W      = aim_bot_pkg::ROW_W,
  parameter int ID_W       = aim_bot_pkg::ID_W,
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT    = 65535
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        enable,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0][ROW_W-1:0] rows,
  output logic [N_REQ-1:0]            grant,
  output logic                        udp_trig,
  output logic [ID_W-1:0]             tx_id,
  output logic [ROW_W-1:0]            tx_row,
  input  logic                        read_en,
  output logic                        busy,
  output logic [15:0]                 lines_sent,
  output logic                        timeout_err,
  output logic                        overrun_err
);
  import aim_bot_pkg::sched_state_t;
  import aim_bot_pkg::IDLE;
  import aim_bot_pkg::WAIT_RD;
  import aim_bot_pkg::STREAM;
  import aim_bot_pkg::GAP;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(H_ACT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(IFG_CYCLES + 1);

  sched_state_t  r_state, w_nxt;
  logic [PW-1:0] r_ptr;
  logic [BW-1:0] r_bcnt;
  logic [TW-1:0] r_tcnt;
  logic [GW-1:0] r_gcnt;

  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_vld;
  logic             w_arb, w_first, w_done, w_tmo, w_ovr;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .vld (w_vld)
  );

  always_comb begin
    w_nxt   = r_state;
    w_arb   = 1'b0;
    w_first = 1'b0;
    w_done  = 1'b0;
    w_tmo   = 1'b0;
    w_ovr   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ovr = read_en;
        if (enable && w_vld) begin
          w_arb = 1'b1;
          w_nxt = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (read_en) begin
          w_first = 1'b1;
          if (H_ACT == 1) begin
            w_done = 1'b1;
            w_nxt  = GAP;
          end else begin
            w_nxt = STREAM;
          end
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_tmo = 1'b1;
          w_nxt = GAP;
        end
      end
      STREAM: begin
        if (read_en && r_bcnt == BW'(H_ACT - 1)) begin
          w_done = 1'b1;
          w_nxt  = GAP;
        end
      end
      GAP: begin
        w_ovr = read_en;
        if (r_gcnt == GW'(IFG_CYCLES - 1)) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr       <= PW'(N_REQ - 1);
      r_bcnt      <= '0;
      r_tcnt      <= '0;
      r_gcnt      <= '0;
      grant       <= '0;
      udp_trig    <= 1'b0;
      tx_id       <= '0;
      tx_row      <= '0;
      busy        <= 1'b0;
      lines_sent  <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      grant    <= w_arb ? w_gnt : '0;
      udp_trig <= w_arb;
      if (w_arb) begin
        r_ptr  <= w_idx;
        tx_id  <= ID_W'(w_idx);
        tx_row <= rows[w_idx];
        busy   <= 1'b1;
        r_tcnt <= '0;
      end
      if (r_state == WAIT_RD) r_tcnt <= r_tcnt + 1'b1;
      if (w_first)                          r_bcnt <= BW'(1);
      else if (r_state == STREAM && read_en) r_bcnt <= r_bcnt + 1'b1;
      // gap counter restarts on entry so the idle window is always full length
      if (w_done || w_tmo)    r_gcnt <= '0;
      else if (r_state == GAP) r_gcnt <= r_gcnt + 1'b1;
      if (r_state == GAP && w_nxt == IDLE) busy <= 1'b0;
      if (w_done) lines_sent  <= lines_sent + 16'd1;
      if (w_tmo)  timeout_err <= 1'b1;
      if (w_ovr)  overrun_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_udp_line_scheduler.sv
// Directed bench: table of line packets plus timeout, overrun/enable and reset sequences.
module tb_udp_line_scheduler;
  localparam int N_REQ = 2;
  localparam int H_ACT = 1280;
  localparam int ROW_W = 11;
  localparam int ID_W  = 5;
  localparam int IFG   = 12;
  localparam int TMO   = 100;

  logic                        clk = 1'b0;
  logic                        rstn;
  logic                        enable;
  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0][ROW_W-1:0] rows;
  logic [N_REQ-1:0]            grant;
  logic                        udp_trig;
  logic [ID_W-1:0]             tx_id;
  logic [ROW_W-1:0]            tx_row;
  logic                        read_en;
  logic                        busy;
  logic [15:0]                 lines_sent;
  logic                        timeout_err;
  logic                        overrun_err;

  int n_run  = 0;
  int n_fail = 0;
  int exp_lines = 0;

  udp_line_scheduler #(
    .N_REQ(N_REQ), .H_ACT(H_ACT), .ROW_W(ROW_W), .ID_W(ID_W),
    .IFG_CYCLES(IFG), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .req(req), .rows(rows),
    .grant(grant), .udp_trig(udp_trig), .tx_id(tx_id), .tx_row(tx_row),
    .read_en(read_en), .busy(busy), .lines_sent(lines_sent),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [10:0] row0;
    logic [10:0] row1;
    bit          gapped;
    logic [1:0]  req_after;
    logic [1:0]  exp_gnt;
    int          exp_id;
    int          exp_row;
  } vec_t;

  vec_t tv[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_trig(input string nm);
    int n = 0;
    while (udp_trig !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_trig_seen"}, {31'd0, udp_trig}, 1);
  endtask

  task automatic run_bytes(input int nb, input bit gapped);
    for (int i = 0; i < nb; i++) begin
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      if (gapped) tick();
    end
  endtask

  task automatic wait_idle(input string nm, input int exp_n);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk({nm, "_gap_len"}, n, exp_n);
  endtask

  initial begin
    int n;
    int gcount;
    rstn = 1'b0; enable = 1'b1; req = '0; read_en = 1'b0; rows = '0;
    tick(); tick();
    chk("rst_grant", {30'd0, grant}, 0);
    chk("rst_trig", {31'd0, udp_trig}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_lines", {16'd0, lines_sent}, 0);
    chk("rst_errs", {30'd0, timeout_err, overrun_err}, 0);
    chk("rst_txid_row", {16'd0, tx_id, tx_row}, 0);
    rstn = 1'b1;
    tick();

    tv[0] = '{2'b01, 11'd37, 11'd0, 1'b0, 2'b00, 2'b01, 0, 37};
    tv[1] = '{2'b10, 11'd0,  11'd9, 1'b1, 2'b00, 2'b10, 1, 9};
    tv[2] = '{2'b11, 11'd5,  11'd6, 1'b0, 2'b11, 2'b01, 0, 5};
    tv[3] = '{2'b11, 11'd5,  11'd6, 1'b0, 2'b11, 2'b10, 1, 6};
    tv[4] = '{2'b11, 11'd5,  11'd6, 1'b0, 2'b11, 2'b01, 0, 5};
    tv[5] = '{2'b11, 11'd5,  11'd6, 1'b0, 2'b00, 2'b10, 1, 6};

    for (int e = 0; e < 6; e++) begin
      rows[0] = tv[e].row0;
      rows[1] = tv[e].row1;
      req     = tv[e].req;
      wait_trig($sformatf("v%0d", e));
      chk($sformatf("v%0d_grant", e), {30'd0, grant}, {30'd0, tv[e].exp_gnt});
      chk($sformatf("v%0d_id", e), {27'd0, tx_id}, tv[e].exp_id);
      chk($sformatf("v%0d_row", e), {21'd0, tx_row}, tv[e].exp_row);
      chk($sformatf("v%0d_busy", e), {31'd0, busy}, 1);
      req = tv[e].req_after;
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      chk($sformatf("v%0d_pulse", e), {29'd0, udp_trig, grant}, 0);
      if (tv[e].gapped) tick();
      run_bytes(H_ACT - 2, tv[e].gapped);
      chk($sformatf("v%0d_lines_pre", e), {16'd0, lines_sent}, exp_lines);
      run_bytes(1, tv[e].gapped);
      exp_lines++;
      chk($sformatf("v%0d_lines", e), {16'd0, lines_sent}, exp_lines);
      wait_idle($sformatf("v%0d", e), tv[e].gapped ? IFG - 1 : IFG);
      chk($sformatf("v%0d_row_hold", e), {21'd0, tx_row}, tv[e].exp_row);
      chk($sformatf("v%0d_ovr", e), {31'd0, overrun_err}, 0);
    end

    // timeout: requester 0 granted, no read_en ever arrives
    req = 2'b11;
    wait_trig("tmo");
    chk("tmo_grant", {30'd0, grant}, 2'b01);
    req = 2'b10;
    n = 0;
    while (timeout_err !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, TMO);
    chk("tmo_lines", {16'd0, lines_sent}, exp_lines);
    chk("tmo_busy", {31'd0, busy}, 1);
    n = 0;
    while (udp_trig !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_regrant_dly", n, IFG + 1);
    chk("tmo_regrant", {30'd0, grant}, 2'b10);
    chk("tmo_regrant_id", {27'd0, tx_id}, 1);
    req = 2'b00;
    run_bytes(H_ACT, 1'b0);
    exp_lines++;
    chk("tmo_next_lines", {16'd0, lines_sent}, exp_lines);
    wait_idle("tmo_next", IFG);
    chk("tmo_sticky", {31'd0, timeout_err}, 1);

    // overrun in IDLE, then enable dropped mid-stream
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("ovr_set", {31'd0, overrun_err}, 1);
    chk("ovr_idle", {30'd0, busy, udp_trig}, 0);
    chk("ovr_lines", {16'd0, lines_sent}, exp_lines);
    req = 2'b11;
    wait_trig("en");
    chk("en_grant", {30'd0, grant}, 2'b01);
    run_bytes(600, 1'b0);
    enable = 1'b0;
    run_bytes(H_ACT - 600, 1'b0);
    exp_lines++;
    chk("en_lines", {16'd0, lines_sent}, exp_lines);
    gcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant !== 2'b00 || udp_trig !== 1'b0) gcount++;
    end
    chk("en_no_grant", gcount, 0);
    chk("en_idle", {31'd0, busy}, 0);
    enable = 1'b1;
    wait_trig("en_resume");
    chk("en_resume_grant", {30'd0, grant}, 2'b10);

    // asynchronous reset mid-stream
    run_bytes(600, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mrst_outs", {25'd0, grant, udp_trig, busy, timeout_err, overrun_err}, 0);
    chk("mrst_lines", {16'd0, lines_sent}, 0);
    chk("mrst_txid_row", {16'd0, tx_id, tx_row}, 0);
    tick();
    rstn = 1'b1;
    wait_trig("mrst");
    chk("mrst_grant", {30'd0, grant}, 2'b01);
    chk("mrst_row", {21'd0, tx_row}, 5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
